// File: rtl/inv_tb_pkg.sv
// Shared types and widths for the NMOS inverter stimulus/check slice.
package inv_tb_pkg;

    localparam int CODE_W = 4;
    localparam int ERR_W  = 8;

    localparam logic [CODE_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } inv_chk_state_e;

endpackage

// File: rtl/inv_stim_checker_if.sv
// Stimulus/response bundle between the checker and the inverter cell plus its controller.
interface inv_stim_checker_if;
    import inv_tb_pkg::*;

    logic              start;
    logic              dut_out;
    logic              dut_in;
    logic [CODE_W-1:0] vec_code;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_cnt;
    logic              fail_valid;
    logic [CODE_W-1:0] fail_code;

    modport master (
        output start, dut_out,
        input  dut_in, vec_code, busy, done, err_cnt, fail_valid, fail_code
    );

    modport slave (
        input  start, dut_out,
        output dut_in, vec_code, busy, done, err_cnt, fail_valid, fail_code
    );

endinterface

// File: rtl/bcd_counter.sv
// BCD code index: clear, increment, wraps 9 -> 0, terminal count at NVEC-1.
module bcd_counter
    import inv_tb_pkg::*;
#(
    parameter int NVEC = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [CODE_W-1:0] cnt,
    output logic              tc
);

    localparam logic [CODE_W-1:0] LAST = CODE_W'(NVEC - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == BCD_MAX) ? '0 : cnt + CODE_W'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/inv_stim_checker.sv
// Walks BCD codes into the inverter, waits SETTLE cycles, and checks the inverted response.
module inv_stim_checker
    import inv_tb_pkg::*;
#(
    parameter int NVEC     = 10,
    parameter int SETTLE   = 2,
    parameter int STIM_BIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    inv_stim_checker_if.slave  bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    inv_chk_state_e    state;
    logic [3:0]        settle_cnt;
    logic [CODE_W-1:0] idx;
    logic              idx_tc;
    logic              idx_clr;
    logic              idx_inc;
    logic              mismatch;

    logic              dut_in_r;
    logic [CODE_W-1:0] vec_code_r;
    logic              busy_r;
    logic              done_r;
    logic [ERR_W-1:0]  err_r;
    logic              fail_valid_r;
    logic [CODE_W-1:0] fail_code_r;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    assign idx_clr = (state == IDLE) && bus.start;
    assign idx_inc = (state == SAMPLE) && !idx_tc;

    bcd_counter #(
        .NVEC (NVEC)
    ) u_idx (
        .clk (clk),
        .rst (rst),
        .clr (idx_clr),
        .inc (idx_inc),
        .cnt (idx),
        .tc  (idx_tc)
    );

    // Case-inequality so an X or Z response from the cell counts as a failure.
    assign mismatch = (bus.dut_out !== ~dut_in_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            dut_in_r     <= 1'b1;
            vec_code_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= '0;
            fail_valid_r <= 1'b0;
            fail_code_r  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= DRIVE;
                        busy_r       <= 1'b1;
                        err_r        <= '0;
                        fail_valid_r <= 1'b0;
                        fail_code_r  <= '0;
                    end
                end
                DRIVE: begin
                    dut_in_r   <= idx[STIM_BIT];
                    vec_code_r <= idx;
                    settle_cnt <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_r <= sat_inc(err_r);
                        if (!fail_valid_r) begin
                            fail_valid_r <= 1'b1;
                            fail_code_r  <= vec_code_r;
                        end
                    end
                    if (idx_tc) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dut_in     = dut_in_r;
    assign bus.vec_code   = vec_code_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err_cnt    = err_r;
    assign bus.fail_valid = fail_valid_r;
    assign bus.fail_code  = fail_code_r;

endmodule

// File: tb/tb_inv_stim_checker.sv
// Self-checking bench: two checker instances driven by a behavioural inverter with injectable faults.
module tb_inv_stim_checker;
    import inv_tb_pkg::*;

    localparam int NV[2] = '{10, 10};
    localparam int ST[2] = '{2, 1};
    localparam int SB[2] = '{0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests  = 0;
    int   failed = 0;

    // Inverter behaviour per instance: 0 ideal, 1 stuck-0, 2 stuck-1, 3 X on code 7, 4 per-code flip mask.
    int          mode [2];
    logic [15:0] mask [2];
    logic        start_i [2];

    logic        busy_o [2];
    logic        done_o [2];
    logic        din_o  [2];
    logic        fv_o   [2];
    logic [3:0]  vc_o   [2];
    logic [3:0]  fc_o   [2];
    logic [7:0]  err_o  [2];

    inv_stim_checker_if if0 ();
    inv_stim_checker_if if1 ();

    inv_stim_checker #(.NVEC(NV[0]), .SETTLE(ST[0]), .STIM_BIT(SB[0])) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    inv_stim_checker #(.NVEC(NV[1]), .SETTLE(ST[1]), .STIM_BIT(SB[1])) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    function automatic logic inv_model(input int md, input logic [15:0] mk,
                                       input logic din, input logic [3:0] code);
        case (md)
            0:       return ~din;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (code == 4'd7) ? 1'bx : ~din;
            default: return mk[code] ? din : ~din;
        endcase
    endfunction

    assign if0.dut_out = inv_model(mode[0], mask[0], if0.dut_in, if0.vec_code);
    assign if1.dut_out = inv_model(mode[1], mask[1], if1.dut_in, if1.vec_code);
    assign if0.start   = start_i[0];
    assign if1.start   = start_i[1];

    assign busy_o[0] = if0.busy;       assign busy_o[1] = if1.busy;
    assign done_o[0] = if0.done;       assign done_o[1] = if1.done;
    assign din_o[0]  = if0.dut_in;     assign din_o[1]  = if1.dut_in;
    assign fv_o[0]   = if0.fail_valid; assign fv_o[1]   = if1.fail_valid;
    assign vc_o[0]   = if0.vec_code;   assign vc_o[1]   = if1.vec_code;
    assign fc_o[0]   = if0.fail_code;  assign fc_o[1]   = if1.fail_code;
    assign err_o[0]  = if0.err_cnt;    assign err_o[1]  = if1.err_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: apply codes 0..NVEC-1 through the inverter model and score each response.
    task automatic model_run(input int w, output int e, output logic v, output logic [3:0] c);
        logic [3:0] code;
        logic       din;
        e = 0;
        v = 1'b0;
        c = 4'd0;
        for (int k = 0; k < NV[w]; k++) begin
            code = 4'(k);
            din  = code[SB[w]];
            if (inv_model(mode[w], mask[w], din, code) !== ~din) begin
                if (e < 255) e++;
                if (!v) begin
                    v = 1'b1;
                    c = code;
                end
            end
        end
    endtask

    task automatic run_check(input int w, input string tag, input bit hold);
        int         dexp;
        int         ev;
        int         per;
        logic       fv;
        logic [3:0] fc;
        logic [3:0] ci;
        dexp = NV[w] * (ST[w] + 2) + 1;
        per  = ST[w] + 2;
        model_run(w, ev, fv, fc);
        @(posedge clk); #1;
        start_i[w] = 1'b1;
        for (int cyc = 1; cyc <= dexp + 1; cyc++) begin
            @(posedge clk); #1;
            if (!hold) start_i[w] = 1'b0;
            check({tag, ".busy"}, 32'(busy_o[w]), 32'(cyc <= dexp));
            check({tag, ".done"}, 32'(done_o[w]), 32'(cyc == dexp));
            if (cyc < dexp && (cyc % per) == 0) begin
                ci = 4'(cyc / per - 1);
                check({tag, ".vec_code"}, 32'(vc_o[w]), 32'(ci));
                check({tag, ".dut_in"}, 32'(din_o[w]), 32'(ci[SB[w]]));
            end
        end
        check({tag, ".err_cnt"}, 32'(err_o[w]), 32'(ev));
        check({tag, ".fail_valid"}, 32'(fv_o[w]), 32'(fv));
        if (fv) check({tag, ".fail_code"}, 32'(fc_o[w]), 32'(fc));
    endtask

    task automatic check_reset_vals(input int w, input string tag);
        check({tag, ".busy"}, 32'(busy_o[w]), 32'd0);
        check({tag, ".done"}, 32'(done_o[w]), 32'd0);
        check({tag, ".dut_in"}, 32'(din_o[w]), 32'd1);
        check({tag, ".vec_code"}, 32'(vc_o[w]), 32'd0);
        check({tag, ".err_cnt"}, 32'(err_o[w]), 32'd0);
        check({tag, ".fail_valid"}, 32'(fv_o[w]), 32'd0);
        check({tag, ".fail_code"}, 32'(fc_o[w]), 32'd0);
    endtask

    initial begin
        int         ndone;
        int         exp_e;
        logic [3:0] ci;

        rst        = 1'b1;
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        mode[0]    = 0;
        mode[1]    = 0;
        mask[0]    = '0;
        mask[1]    = '0;

        // Power-on reset values on both instances.
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals(0, "por0");
        check_reset_vals(1, "por1");
        check("por0.state", 32'(u_dut0.state), 32'(IDLE));
        rst = 1'b0;

        // Directed fault patterns on the default instance.
        mode[0] = 0; run_check(0, "ideal", 1'b0);
        mode[0] = 1; run_check(0, "stuck0", 1'b0);
        mode[0] = 2; run_check(0, "stuck1", 1'b0);
        mode[0] = 0; run_check(0, "rerun_ideal", 1'b0);

        // X response on code 7 only, driving bit 1 of the code.
        mode[1] = 3; run_check(1, "xcode7", 1'b0);

        // Randomised per-code faults on both instances.
        for (int r = 0; r < 6; r++) begin
            mode[r % 2] = $urandom_range(0, 4);
            mask[r % 2] = 16'($urandom);
            run_check(r % 2, "rand", 1'b0);
        end

        // Start held high: one run, then a new run accepted the cycle after DONE.
        mode[0] = 0;
        run_check(0, "hold", 1'b1);
        @(posedge clk); #1;
        check("hold.restart_busy", 32'(busy_o[0]), 32'd1);
        check("hold.restart_err", 32'(err_o[0]), 32'd0);
        start_i[0] = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < NV[0] * (ST[0] + 2) + 2; cyc++) begin
            @(posedge clk); #1;
            if (done_o[0] === 1'b1) ndone++;
        end
        check("hold.second_done_count", 32'(ndone), 32'd1);
        check("hold.second_idle", 32'(busy_o[0]), 32'd0);

        // Reset in cycle 20 of a faulty run aborts it without a done pulse.
        mode[0] = 1;
        exp_e   = 0;
        for (int k = 0; k < NV[0]; k++) begin
            ci = 4'(k);
            if ((k + 1) * (ST[0] + 2) < 20 &&
                inv_model(mode[0], mask[0], ci[SB[0]], ci) !== ~ci[SB[0]]) exp_e++;
        end
        @(posedge clk); #1;
        start_i[0] = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            start_i[0] = 1'b0;
        end
        check("abort.err_before", 32'(err_o[0]), 32'(exp_e));
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort.state", 32'(u_dut0.state), 32'(IDLE));
        check_reset_vals(0, "abort");
        rst   = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk); #1;
            if (done_o[0] === 1'b1) ndone++;
        end
        check("abort.no_done", 32'(ndone), 32'd0);
        check("abort.stays_idle", 32'(busy_o[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
